tile_xy_line_router: RTL and testbench

Parametrised successor of the tile X/Y cache-line FIFO: one axis stage of the tile mesh that moves whole cache-line request packets along a bidirectional ring segment. It adds real valid/ready back-pressure on every port, configurable depth and widths, same-tile loopback, round-robin local ejection, and an anti-starvation guard for local injection. One instance sits per axis per tile, between the L2 miss/writeback logic (inject/eject) and the neighbouring tiles (links).

---
 rtl/tile_xy_pkg.sv | 36 +++
 rtl/tile_line_fifo.sv | 50 +++++
 rtl/tile_xy_line_router.sv | 178 +++++++++++++++++
 tb/tb_tile_xy_line_router.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_xy_pkg.sv
// Shared packet layout, widths and direction/tag encodings for the tile X/Y line router.
package tile_xy_pkg;

  localparam int DATA_W  = 528;
  localparam int ADDR_W  = 37;
  localparam int SZ_W    = 40;
  localparam int COORD_W = 5;
  localparam int PKT_W   = DATA_W + ADDR_W + SZ_W + 1 + 1 + COORD_W + COORD_W;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  addr;
    logic [SZ_W-1:0]    sz;
    logic               shared;
    logic               expun;
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
  } pkt_t;

  typedef enum logic {
    DIR_BACK = 1'b0,
    DIR_FWD  = 1'b1
  } dir_e;

  // Destination of the inject holding register: one of the two links or local loopback.
  typedef enum logic [1:0] {
    TAG_BACK  = 2'd0,
    TAG_FWD   = 2'd1,
    TAG_LOCAL = 2'd2
  } tag_e;

  function automatic logic [COORD_W-1:0] route_coord(input pkt_t p, input logic axis);
    return axis ? p.ty : p.tx;
  endfunction

endpackage

// File: rtl/tile_line_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; a push while full is dropped.
module tile_line_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/tile_xy_line_router.sv
// One axis stage of the tile mesh: pass/eject queues per link direction, a one-entry
// inject holding register with starvation guard, and round-robin local ejection.
module tile_xy_line_router
  import tile_xy_pkg::*;
#(
  parameter logic [4:0] TILE_X     = 5'd0,
  parameter logic [4:0] TILE_Y     = 5'd0,
  parameter bit         AXIS       = 1'b0,
  parameter int         DEPTH      = 8,
  parameter int         STARVE_LIM = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [1:0]                           lnk_in_vld,
  input  pkt_t [1:0]                           lnk_in_pkt,
  output logic [1:0]                           lnk_in_rdy,
  output logic [1:0]                           lnk_out_vld,
  output pkt_t [1:0]                           lnk_out_pkt,
  input  logic [1:0]                           lnk_out_rdy,
  input  logic                                 inj_vld,
  input  pkt_t                                 inj_pkt,
  output logic                                 inj_rdy,
  output logic                                 ej_vld,
  output pkt_t                                 ej_pkt,
  input  logic                                 ej_rdy,
  output logic [3:0][$clog2(DEPTH+1)-1:0]      occ
);

  localparam logic [COORD_W-1:0] ME = AXIS ? TILE_Y : TILE_X;
  localparam int                 SW = $clog2(STARVE_LIM + 1);

  pkt_t [1:0]         pass_head, ej_head;
  logic [1:0]         pass_full, pass_empty, ej_full, ej_empty;
  logic [1:0]         pass_push, ej_push, pass_pop, ej_pop;
  logic [1:0]         inj_cand;
  logic               loop_cand, hold_xfer;

  logic               hold_vld_q, hold_vld_d;
  pkt_t               hold_pkt_q, hold_pkt_d;
  tag_e               hold_tag_q, hold_tag_d;
  logic [1:0]         out_sel_q, out_sel_d;
  logic [1:0]         out_lock_q, out_lock_d;
  logic [1:0][SW-1:0] starve_q, starve_d;
  logic [1:0]         rr_q, rr_d;
  logic [1:0]         ej_sel_q, ej_sel_d;
  logic               ej_lock_q, ej_lock_d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dir
    logic in_local;
    assign in_local       = (route_coord(lnk_in_pkt[gi], AXIS) == ME);
    assign lnk_in_rdy[gi] = ~pass_full[gi] & ~ej_full[gi];
    assign pass_push[gi]  = lnk_in_vld[gi] & lnk_in_rdy[gi] & ~in_local;
    assign ej_push[gi]    = lnk_in_vld[gi] & lnk_in_rdy[gi] & in_local;

    tile_line_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_pass (
      .clk(clk), .rst(rst), .push(pass_push[gi]), .din(lnk_in_pkt[gi]), .pop(pass_pop[gi]),
      .dout(pass_head[gi]), .count(occ[gi]), .full(pass_full[gi]), .empty(pass_empty[gi])
    );

    tile_line_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_ej (
      .clk(clk), .rst(rst), .push(ej_push[gi]), .din(lnk_in_pkt[gi]), .pop(ej_pop[gi]),
      .dout(ej_head[gi]), .count(occ[gi+2]), .full(ej_full[gi]), .empty(ej_empty[gi])
    );
  end

  assign inj_cand[0] = hold_vld_q && (hold_tag_q == TAG_BACK);
  assign inj_cand[1] = hold_vld_q && (hold_tag_q == TAG_FWD);
  assign loop_cand   = hold_vld_q && (hold_tag_q == TAG_LOCAL);
  assign inj_rdy     = ~hold_vld_q;

  always_comb begin
    logic                 fresh;
    logic                 found;
    logic [1:0]           ej_pick;
    logic [3:0]           ej_cand;
    logic [COORD_W-1:0]   tgt;
    int                   idx;
    fresh       = 1'b0;
    found       = 1'b0;
    ej_pick     = rr_q;
    ej_cand     = {1'b0, loop_cand, ~ej_empty[1], ~ej_empty[0]};
    tgt         = route_coord(inj_pkt, AXIS);
    idx         = 0;
    hold_xfer   = 1'b0;
    hold_vld_d  = hold_vld_q;
    hold_pkt_d  = hold_pkt_q;
    hold_tag_d  = hold_tag_q;
    out_sel_d   = out_sel_q;
    out_lock_d  = '0;
    starve_d    = starve_q;
    pass_pop    = '0;
    ej_pop      = '0;
    lnk_out_vld = '0;
    lnk_out_pkt = '0;
    ej_vld      = 1'b0;
    ej_pkt      = '0;
    ej_sel_d    = ej_sel_q;
    ej_lock_d   = 1'b0;
    rr_d        = rr_q;

    // A presented-but-unaccepted output keeps its previous grant so the packet stays stable.
    for (int d = 0; d < 2; d++) begin
      fresh        = inj_cand[d] && (pass_empty[d] || (starve_q[d] >= SW'(STARVE_LIM)));
      out_sel_d[d] = out_lock_q[d] ? out_sel_q[d] : fresh;
      if (out_sel_d[d]) begin
        lnk_out_vld[d] = 1'b1;
        lnk_out_pkt[d] = hold_pkt_q;
      end else begin
        lnk_out_vld[d] = ~pass_empty[d];
        lnk_out_pkt[d] = pass_head[d];
      end
      out_lock_d[d] = lnk_out_vld[d] & ~lnk_out_rdy[d];
      if (lnk_out_vld[d] && lnk_out_rdy[d]) begin
        if (out_sel_d[d]) begin
          hold_xfer   = 1'b1;
          starve_d[d] = '0;
        end else begin
          pass_pop[d] = 1'b1;
          if (inj_cand[d] && (starve_q[d] < SW'(STARVE_LIM))) starve_d[d] = starve_q[d] + SW'(1);
        end
      end
    end

    for (int k = 0; k < 3; k++) begin
      idx = (int'(rr_q) + k) % 3;
      if (!found && ej_cand[idx]) begin
        found   = 1'b1;
        ej_pick = 2'(idx);
      end
    end
    ej_sel_d  = ej_lock_q ? ej_sel_q : ej_pick;
    ej_vld    = ej_cand[ej_sel_d];
    ej_lock_d = ej_vld & ~ej_rdy;
    case (ej_sel_d)
      2'd0:    ej_pkt = ej_head[0];
      2'd1:    ej_pkt = ej_head[1];
      default: ej_pkt = hold_pkt_q;
    endcase
    if (ej_vld && ej_rdy) begin
      rr_d = (ej_sel_d == 2'd2) ? 2'd0 : ej_sel_d + 2'd1;
      if (ej_sel_d == 2'd2) hold_xfer = 1'b1;
      else                  ej_pop[ej_sel_d[0]] = 1'b1;
    end

    if (hold_xfer) begin
      hold_vld_d = 1'b0;
    end else if (inj_vld && !hold_vld_q) begin
      hold_vld_d = 1'b1;
      hold_pkt_d = inj_pkt;
      hold_tag_d = (tgt > ME) ? TAG_FWD : ((tgt < ME) ? TAG_BACK : TAG_LOCAL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld_q <= 1'b0;
      hold_pkt_q <= '0;
      hold_tag_q <= TAG_BACK;
      out_sel_q  <= '0;
      out_lock_q <= '0;
      starve_q   <= '0;
      rr_q       <= '0;
      ej_sel_q   <= '0;
      ej_lock_q  <= 1'b0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_pkt_q <= hold_pkt_d;
      hold_tag_q <= hold_tag_d;
      out_sel_q  <= out_sel_d;
      out_lock_q <= out_lock_d;
      starve_q   <= starve_d;
      rr_q       <= rr_d;
      ej_sel_q   <= ej_sel_d;
      ej_lock_q  <= ej_lock_d;
    end
  end

endmodule

// File: tb/tb_tile_xy_line_router.sv
// Scoreboard bench for tile_xy_line_router (TILE_X=2, AXIS=0, DEPTH=8, STARVE_LIM=4).
module tb_tile_xy_line_router;
  import tile_xy_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          lnk_in_vld, lnk_in_rdy, lnk_out_vld, lnk_out_rdy;
  pkt_t [1:0]          lnk_in_pkt, lnk_out_pkt;
  logic                inj_vld, inj_rdy, ej_vld, ej_rdy;
  pkt_t                inj_pkt, ej_pkt;
  logic [3:0][CW-1:0]  occ;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   next_id = 1;
  pkt_t exp_q0[$], exp_q1[$], exp_qe[$];
  pkt_t mon_e;

  always #5 clk = ~clk;

  tile_xy_line_router #(
    .TILE_X(5'd2), .TILE_Y(5'd3), .AXIS(1'b0), .DEPTH(DEPTH), .STARVE_LIM(4)
  ) dut (
    .clk(clk), .rst(rst),
    .lnk_in_vld(lnk_in_vld), .lnk_in_pkt(lnk_in_pkt), .lnk_in_rdy(lnk_in_rdy),
    .lnk_out_vld(lnk_out_vld), .lnk_out_pkt(lnk_out_pkt), .lnk_out_rdy(lnk_out_rdy),
    .inj_vld(inj_vld), .inj_pkt(inj_pkt), .inj_rdy(inj_rdy),
    .ej_vld(ej_vld), .ej_pkt(ej_pkt), .ej_rdy(ej_rdy),
    .occ(occ)
  );

  task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pkt_t mk_pkt(input int id, input logic [4:0] tx);
    pkt_t p;
    p                 = '0;
    p.data[31:0]      = id;
    p.data[527:496]   = ~id;
    p.addr            = 37'(id) * 37'd3;
    p.sz              = 40'(id) << 8;
    p.shared          = id[0];
    p.expun           = id[1];
    p.tx              = tx;
    p.ty              = id[4:0];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: a transfer happens at the next posedge when vld&rdy hold at negedge.
  always @(negedge clk) begin
    if (rst) begin
      if (lnk_out_vld[0] && lnk_out_rdy[0]) begin
        $display("%0t xfer out0 id=%0d", $time, lnk_out_pkt[0].data[31:0]);
        if (exp_q0.size() == 0) check_eq("out0_unexpected", 1, 0);
        else begin mon_e = exp_q0.pop_front(); check_eq("out0_pkt", lnk_out_pkt[0], mon_e); end
      end
      if (lnk_out_vld[1] && lnk_out_rdy[1]) begin
        $display("%0t xfer out1 id=%0d", $time, lnk_out_pkt[1].data[31:0]);
        if (exp_q1.size() == 0) check_eq("out1_unexpected", 1, 0);
        else begin mon_e = exp_q1.pop_front(); check_eq("out1_pkt", lnk_out_pkt[1], mon_e); end
      end
      if (ej_vld && ej_rdy) begin
        $display("%0t xfer ej id=%0d", $time, ej_pkt.data[31:0]);
        if (exp_qe.size() == 0) check_eq("ej_unexpected", 1, 0);
        else begin mon_e = exp_qe.pop_front(); check_eq("ej_pkt", ej_pkt, mon_e); end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p, pa, pb, pc, pd, pl;
    pkt_t ps[8];
    logic [4:0] txs[3];
    logic [2:0] routes[3];
    int   mcnt[2];
    logic do_push, do_pop;

    lnk_in_vld  = '0;
    lnk_in_pkt  = '0;
    lnk_out_rdy = 2'b11;
    inj_vld     = 1'b0;
    inj_pkt     = '0;
    ej_rdy      = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_lnk_out_vld", lnk_out_vld, 2'b00);
    check_eq("rst_ej_vld", ej_vld, 1'b0);
    check_eq("rst_inj_rdy", inj_rdy, 1'b1);
    check_eq("rst_lnk_in_rdy", lnk_in_rdy, 2'b11);
    check_eq("rst_occ", occ, '0);
    rst = 1'b1;
    tick();

    // Pass-through fill on fwd with the output blocked, then drain
    lnk_out_rdy = 2'b01;
    for (int i = 0; i < 9; i++) begin
      p = mk_pkt(next_id, 5'd5);
      next_id++;
      lnk_in_vld[1] = 1'b1;
      lnk_in_pkt[1] = p;
      @(negedge clk);
      check_eq("fill_in_rdy1", lnk_in_rdy[1], (i < 8));
      if (i < 8) exp_q1.push_back(p);
      tick();
    end
    lnk_in_vld = '0;
    check_eq("fill_occ1", occ[1], 8);
    check_eq("fill_out_vld1", lnk_out_vld[1], 1'b1);
    lnk_out_rdy = 2'b11;
    repeat (8) tick();
    check_eq("drain_sb1_left", exp_q1.size(), 0);
    check_eq("drain_occ1", occ[1], 0);

    // Reset mid-stream with three packets held in pass1
    lnk_out_rdy = 2'b01;
    for (int i = 0; i < 3; i++) begin
      lnk_in_vld[1] = 1'b1;
      lnk_in_pkt[1] = mk_pkt(next_id, 5'd5);
      next_id++;
      tick();
    end
    lnk_in_vld = '0;
    check_eq("pre_rst_occ1", occ[1], 3);
    check_eq("pre_rst_vld1", lnk_out_vld[1], 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_lnk_out_vld", lnk_out_vld, 2'b00);
    check_eq("midrst_occ", occ, '0);
    check_eq("midrst_lnk_in_rdy", lnk_in_rdy, 2'b11);
    check_eq("midrst_inj_rdy", inj_rdy, 1'b1);
    check_eq("midrst_ej_vld", ej_vld, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    lnk_out_rdy = 2'b11;
    p = mk_pkt(next_id, 5'd5);
    next_id++;
    lnk_in_vld[1] = 1'b1;
    lnk_in_pkt[1] = p;
    exp_q1.push_back(p);
    tick();
    lnk_in_vld = '0;
    check_eq("postrst_latency_vld1", lnk_out_vld[1], 1'b1);
    tick();
    check_eq("postrst_sb1_left", exp_q1.size(), 0);

    // Eject round-robin: ej0, ej1, loopback, ej0, ej1
    ej_rdy = 1'b0;
    pa = mk_pkt(next_id, 5'd2);     next_id++;
    pb = mk_pkt(next_id, 5'd2);     next_id++;
    pl = mk_pkt(next_id, 5'd2);     next_id++;
    pc = mk_pkt(next_id, 5'd2);     next_id++;
    pd = mk_pkt(next_id, 5'd2);     next_id++;
    lnk_in_vld    = 2'b11;
    lnk_in_pkt[0] = pa;
    lnk_in_pkt[1] = pb;
    inj_vld       = 1'b1;
    inj_pkt       = pl;
    tick();
    inj_vld       = 1'b0;
    lnk_in_pkt[0] = pc;
    lnk_in_pkt[1] = pd;
    tick();
    lnk_in_vld = '0;
    exp_qe.push_back(pa);
    exp_qe.push_back(pb);
    exp_qe.push_back(pl);
    exp_qe.push_back(pc);
    exp_qe.push_back(pd);
    check_eq("rr_ej_vld", ej_vld, 1'b1);
    check_eq("rr_occ_ej0", occ[2], 2);
    check_eq("rr_occ_ej1", occ[3], 2);
    check_eq("rr_lnk_out_idle", lnk_out_vld, 2'b00);
    ej_rdy = 1'b1;
    repeat (5) tick();
    check_eq("rr_sbe_left", exp_qe.size(), 0);
    check_eq("rr_inj_rdy", inj_rdy, 1'b1);

    // Inject starvation: pass1 full, inject wins the 5th arbitration
    lnk_out_rdy = 2'b01;
    for (int i = 0; i < 8; i++) begin
      ps[i] = mk_pkt(next_id, 5'd5);
      next_id++;
      lnk_in_vld[1] = 1'b1;
      lnk_in_pkt[1] = ps[i];
      tick();
    end
    lnk_in_vld = '0;
    pl = mk_pkt(next_id, 5'd7);
    next_id++;
    inj_vld = 1'b1;
    inj_pkt = pl;
    tick();
    inj_vld = 1'b0;
    check_eq("starve_inj_held", inj_rdy, 1'b0);
    for (int i = 0; i < 4; i++) exp_q1.push_back(ps[i]);
    exp_q1.push_back(pl);
    for (int i = 4; i < 8; i++) exp_q1.push_back(ps[i]);
    lnk_out_rdy = 2'b11;
    repeat (9) tick();
    check_eq("starve_sb1_left", exp_q1.size(), 0);
    check_eq("starve_inj_rdy", inj_rdy, 1'b1);

    // Inject direction: TX=1 -> back, TX=2 -> eject, TX=4 -> fwd, each one cycle later
    txs[0] = 5'd1; routes[0] = 3'b001;
    txs[1] = 5'd2; routes[1] = 3'b100;
    txs[2] = 5'd4; routes[2] = 3'b010;
    for (int k = 0; k < 3; k++) begin
      p = mk_pkt(next_id, txs[k]);
      next_id++;
      if (routes[k][0]) exp_q0.push_back(p);
      else if (routes[k][1]) exp_q1.push_back(p);
      else exp_qe.push_back(p);
      inj_vld = 1'b1;
      inj_pkt = p;
      tick();
      inj_vld = 1'b0;
      check_eq("injdir_route", {ej_vld, lnk_out_vld}, routes[k]);
      tick();
      tick();
      check_eq("injdir_inj_rdy", inj_rdy, 1'b1);
    end

    // Random push/pop through both pass queues, wrapping the pointers several times
    mcnt[0] = 0;
    mcnt[1] = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      lnk_in_vld[0] = ($urandom_range(0, 3) != 0);
      lnk_in_pkt[0] = mk_pkt(next_id, 5'($urandom_range(0, 1)));
      next_id++;
      lnk_in_vld[1] = ($urandom_range(0, 3) != 0);
      lnk_in_pkt[1] = mk_pkt(next_id, 5'($urandom_range(3, 31)));
      next_id++;
      lnk_out_rdy = 2'($urandom_range(0, 3));
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_eq("wrap_in_rdy", lnk_in_rdy[d], (mcnt[d] < DEPTH));
        check_eq("wrap_occ", occ[d], mcnt[d]);
        check_eq("wrap_out_vld", lnk_out_vld[d], (mcnt[d] > 0));
        do_push = lnk_in_vld[d] && (mcnt[d] < DEPTH);
        do_pop  = (mcnt[d] > 0) && lnk_out_rdy[d];
        if (do_push) begin
          if (d == 0) exp_q0.push_back(lnk_in_pkt[0]);
          else        exp_q1.push_back(lnk_in_pkt[1]);
        end
        mcnt[d] = mcnt[d] + int'(do_push) - int'(do_pop);
      end
      tick();
    end
    lnk_in_vld  = '0;
    lnk_out_rdy = 2'b11;
    repeat (DEPTH + 2) tick();
    check_eq("wrap_sb0_left", exp_q0.size(), 0);
    check_eq("wrap_sb1_left", exp_q1.size(), 0);
    check_eq("final_sbe_left", exp_qe.size(), 0);
    check_eq("final_occ", occ, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
